// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared state encoding and command validation for the copy engine
package mem_copy_pkg;

  typedef enum logic [1:0] {IDLE, FILL, COPY, FINISH} state_t;

  // A forward overlap further than one word would read words the copy has already overwritten.
  function automatic logic cmd_reject(input int unsigned src, input int unsigned dst,
                                      input int unsigned len, input int unsigned depth);
    return (src + len > depth) || (dst + len > depth) ||
           ((dst > src + 1) && (dst < src + len));
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - copies a word range within a registered-read memory, one word per cycle
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [WIDTH-1:0]  mem_read_data,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [WIDTH-1:0]  mem_write_data
);

  localparam int SUM_W = ADDR_W + 1;

  state_t            state, next_state;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, idx;
  logic              rej_q;
  logic              cmd_bad, idx_last;
  logic [SUM_W-1:0]  rd_sum, wr_sum;

  assign cmd_bad  = cmd_reject(32'(src_addr), 32'(dst_addr), 32'(len), 32'(DEPTH));
  assign idx_last = (idx == len_q - LEN_W'(1));
  // Read runs one word ahead of the write; on the last word it holds rather than overrunning.
  assign rd_sum   = SUM_W'(src_q) + SUM_W'(idx) + SUM_W'(!idx_last);
  assign wr_sum   = SUM_W'(dst_q) + SUM_W'(idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      rej_q <= 1'b0;
      idx   <= '0;
    end else begin
      if (state == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len;
        rej_q <= cmd_bad;
      end
      if (state == COPY) idx <= idx + LEN_W'(1);
      else               idx <= '0;
    end
  end

  always_comb begin
    next_state     = state;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    mem_read_en    = 1'b0;
    mem_read_addr  = '0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cmd_bad || len == '0) next_state = FINISH;
          else                      next_state = FILL;
        end
      end
      FILL: begin
        busy          = 1'b1;
        mem_read_en   = 1'b1;
        mem_read_addr = src_q;
        next_state    = COPY;
      end
      COPY: begin
        busy           = 1'b1;
        mem_read_en    = 1'b1;
        mem_read_addr  = rd_sum[ADDR_W-1:0];
        mem_write_en   = 1'b1;
        mem_write_addr = wr_sum[ADDR_W-1:0];
        mem_write_data = mem_read_data;
        if (idx_last) next_state = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        error      = rej_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Holding reset silences the memory ports in the same cycle, so nothing commits after it is raised.
    if (rst) begin
      busy           = 1'b0;
      done           = 1'b0;
      error          = 1'b0;
      mem_read_en    = 1'b0;
      mem_read_addr  = '0;
      mem_write_en   = 1'b0;
      mem_write_addr = '0;
      mem_write_data = '0;
    end
  end

endmodule
